// File: rtl/rmgmt_custom_pkg.sv
// Encodings and types for the custom-0 RISC-MGMT extension.
//   CUSTOM0_OPCODE : major opcode claimed by the extension
//   funct3_e       : op codes carried in insn[14:12]; 3'b011 is reserved
//   state_e        : decode-side launch FSM states
//   *_LSB          : bit offsets of the register and funct3 fields
package rmgmt_custom_pkg;

  typedef rv32i_types_pkg::word_t word_t;

  localparam logic [6:0] CUSTOM0_OPCODE = 7'b0001011;

  localparam int unsigned RD_LSB     = 7;
  localparam int unsigned FUNCT3_LSB = 12;
  localparam int unsigned RS1_LSB    = 15;
  localparam int unsigned RS2_LSB    = 20;
  // funct3 MSB set selects a multi-cycle op.
  localparam int unsigned MC_BIT     = 14;

  typedef enum logic [2:0] {
    F3Add  = 3'b000,
    F3Sub  = 3'b001,
    F3Xor  = 3'b010,
    F3Rsvd = 3'b011,
    F3Mul  = 3'b100,
    F3Div  = 3'b101,
    F3Rem  = 3'b110,
    F3Sqrt = 3'b111
  } funct3_e;

  typedef enum logic {
    StIdle = 1'b0,
    StBusy = 1'b1
  } state_e;

endpackage

// File: rtl/rv32i_types_pkg.sv
// Shared RV32I scalar types used across the RISC-MGMT decode and execute paths.
package rv32i_types_pkg;

  typedef logic [31:0] word_t;

endpackage

// File: rtl/rmgmt_custom_lat_ctr.sv
// Down-counter tracking the remaining cycles of a multi-cycle extension op.
// Shared with the execute side.
//   clk_i      : clock
//   rst_ni     : synchronous active-low reset
//   clr_i      : force count to 0 (highest priority)
//   load_i     : load load_val_i
//   dec_i      : decrement by one; holds at 0, never wraps
//   load_val_i : value to load
//   cnt_o      : current count
//   last_o     : count is 1, i.e. this is the final occupied cycle
module rmgmt_custom_lat_ctr #(
  parameter int unsigned Width = 3
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic             load_i,
  input  logic             dec_i,
  input  logic [Width-1:0] load_val_i,
  output logic [Width-1:0] cnt_o,
  output logic             last_o
);

  logic [Width-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - Width'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o  = cnt_q;
  assign last_o = (cnt_q == Width'(1));

endmodule

// File: rtl/rmgmt_custom_decode.sv
// Decode-side consumer of the RISC-MGMT decode interface for one custom-0 extension.
// Claims matching encodings, returns register selects, launches ops into the extension
// execute stage and requests decode bubbles while a multi-cycle op is in flight.
//   CLK          : clock, rising edge
//   nRST         : synchronous active-low reset
//   insn         : instruction word from RISC-MGMT
//   insn_accept  : decode stage advancing this cycle
//   flush        : pipeline flush
//   insn_claim   : extension claims insn (combinational)
//   bubble_req   : decode bubble request while BUSY
//   rsel_s_0/1   : source register selects (0 when not claimed)
//   rsel_d       : destination register select (0 when not claimed)
//   ex_start     : one-cycle launch pulse
//   ex_op, ex_rd : funct3 and rd of the last launched op
//   ex_done      : one-cycle pulse when a multi-cycle op retires
// Optional: define RMGMT_CUSTOM_DECODE_PERF_EN to add saturating perf_claims
// (ex_start pulses) and perf_bubbles (bubble_req cycles) counters.
module rmgmt_custom_decode
  import rmgmt_custom_pkg::*;
#(
  parameter logic [6:0]  OPCODE = CUSTOM0_OPCODE,
  parameter int unsigned MC_LAT = 4
) (
  input  logic        CLK,
  input  logic        nRST,
  input  word_t       insn,
  input  logic        insn_accept,
  input  logic        flush,
  output logic        insn_claim,
  output logic        bubble_req,
  output logic [4:0]  rsel_s_0,
  output logic [4:0]  rsel_s_1,
  output logic [4:0]  rsel_d,
  output logic        ex_start,
  output logic [2:0]  ex_op,
  output logic [4:0]  ex_rd,
  output logic        ex_done
`ifdef RMGMT_CUSTOM_DECODE_PERF_EN
  ,
  output logic [31:0] perf_claims,
  output logic [31:0] perf_bubbles
`endif
);

  localparam int unsigned CntW = $clog2(MC_LAT + 1);

  state_e     state_q, state_d;
  logic       ex_start_q, ex_start_d;
  logic       ex_done_q, ex_done_d;
  logic [2:0] ex_op_q, ex_op_d;
  logic [4:0] ex_rd_q, ex_rd_d;

  logic            ctr_load, ctr_dec, ctr_clr, ctr_last;
  logic [CntW-1:0] unused_cnt;
  logic            unused_insn_hi;

  logic [2:0] funct3;
  logic [4:0] rd;
  logic       match;

  assign funct3 = insn[FUNCT3_LSB +: 3];
  assign rd     = insn[RD_LSB +: 5];
  assign match  = (insn[6:0] == OPCODE) && (funct3 != F3Rsvd);

  assign unused_insn_hi = ^insn[31:25];

  assign insn_claim = match;
  assign rsel_s_0   = match ? insn[RS1_LSB +: 5] : 5'd0;
  assign rsel_s_1   = match ? insn[RS2_LSB +: 5] : 5'd0;
  assign rsel_d     = match ? rd : 5'd0;

  // The counter holds the BUSY cycles remaining including the current one, so the
  // op occupies execute for exactly MC_LAT cycles and last fires when it reads 1.
  rmgmt_custom_lat_ctr #(
    .Width (CntW)
  ) u_lat_ctr (
    .clk_i      (CLK),
    .rst_ni     (nRST),
    .clr_i      (ctr_clr),
    .load_i     (ctr_load),
    .dec_i      (ctr_dec),
    .load_val_i (CntW'(MC_LAT)),
    .cnt_o      (unused_cnt),
    .last_o     (ctr_last)
  );

  always_comb begin
    state_d    = state_q;
    ex_start_d = 1'b0;
    ex_done_d  = 1'b0;
    ex_op_d    = ex_op_q;
    ex_rd_d    = ex_rd_q;
    ctr_load   = 1'b0;
    ctr_dec    = 1'b0;
    ctr_clr    = 1'b0;
    if (flush) begin
      // Flush wins over both launch and completion; latched op fields hold.
      state_d = StIdle;
      ctr_clr = 1'b1;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (match && insn_accept) begin
            ex_start_d = 1'b1;
            ex_op_d    = funct3;
            ex_rd_d    = rd;
            if (insn[MC_BIT]) begin
              state_d  = StBusy;
              ctr_load = 1'b1;
            end
          end
        end
        StBusy: begin
          ctr_dec = 1'b1;
          if (ctr_last) begin
            state_d   = StIdle;
            ex_done_d = 1'b1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_q    <= StIdle;
      ex_start_q <= 1'b0;
      ex_done_q  <= 1'b0;
      ex_op_q    <= 3'd0;
      ex_rd_q    <= 5'd0;
    end else begin
      state_q    <= state_d;
      ex_start_q <= ex_start_d;
      ex_done_q  <= ex_done_d;
      ex_op_q    <= ex_op_d;
      ex_rd_q    <= ex_rd_d;
    end
  end

  assign bubble_req = (state_q == StBusy);
  assign ex_start   = ex_start_q;
  assign ex_done    = ex_done_q;
  assign ex_op      = ex_op_q;
  assign ex_rd      = ex_rd_q;

`ifdef RMGMT_CUSTOM_DECODE_PERF_EN
  logic [31:0] perf_claims_q, perf_bubbles_q;

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      perf_claims_q  <= 32'd0;
      perf_bubbles_q <= 32'd0;
    end else begin
      if (ex_start_q && (perf_claims_q != 32'hFFFF_FFFF)) begin
        perf_claims_q <= perf_claims_q + 32'd1;
      end
      if (bubble_req && (perf_bubbles_q != 32'hFFFF_FFFF)) begin
        perf_bubbles_q <= perf_bubbles_q + 32'd1;
      end
    end
  end

  assign perf_claims  = perf_claims_q;
  assign perf_bubbles = perf_bubbles_q;
`endif

endmodule
